// File: rtl/io_port_pkg.sv
// io_port_pkg: port map, status bit layout and decode helper shared by the I/O port controller.
package io_port_pkg;
  localparam int PORT_FIFO     = 0;
  localparam int PORT_STATUS   = 1;
  localparam int PORT_PINS_A   = 2;
  localparam int PORT_PINS_B   = 3;
  localparam int PORT_OUT_BASE = 4;
  localparam int NUM_OUT       = 4;
  localparam int ST_EMPTY      = 0;
  localparam int ST_FULL       = 1;
  localparam int ST_UNDERFLOW  = 2;
  localparam int ST_OVERRUN    = 3;
  localparam int ST_WIDTH      = 4;
  function automatic logic is_out_port(input int id);
    return id >= PORT_OUT_BASE && id < PORT_OUT_BASE + NUM_OUT;
  endfunction
endpackage

// File: rtl/io_port_fifo.sv
// io_port_fifo: synchronous FIFO; a pop frees the head slot for a same-cycle push even when full.
module io_port_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  output logic                  full
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clock) begin
    if (reset && do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/io_port_controller.sv
// io_port_controller: CPU port-bus peripheral with stream FIFO, sticky status, pin samplers and output registers.
// Define IO_PORT_SYNC_EN to put two-flop synchronizers ahead of the pin sample registers.
module io_port_controller
  import io_port_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ID_WIDTH   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ID_WIDTH-1:0]     port_id,
  input  logic                    port_read,
  input  logic                    port_write,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  input  logic [DATA_WIDTH-1:0]   ext_in_data,
  input  logic                    ext_in_valid,
  output logic                    ext_in_ready,
  input  logic [DATA_WIDTH-1:0]   pins_a,
  input  logic [DATA_WIDTH-1:0]   pins_b,
  output logic [4*DATA_WIDTH-1:0] out_port,
  output logic [3:0]              out_strobe
);
  logic sel_fifo, sel_status, sel_pa, sel_pb, sel_out;
  logic fifo_pop, fifo_empty, fifo_full;
  logic underflow, overrun, clr_sticky, wr_out;
  logic [1:0] out_idx;
  logic [ST_WIDTH-1:0] status;
  logic [DATA_WIDTH-1:0] fifo_rdata, pins_a_q, pins_b_q, pins_a_src, pins_b_src, rd_val;
  logic [NUM_OUT-1:0][DATA_WIDTH-1:0] out_q;
  assign sel_fifo   = int'(port_id) == PORT_FIFO;
  assign sel_status = int'(port_id) == PORT_STATUS;
  assign sel_pa     = int'(port_id) == PORT_PINS_A;
  assign sel_pb     = int'(port_id) == PORT_PINS_B;
  assign sel_out    = is_out_port(int'(port_id));
  assign out_idx    = 2'(int'(port_id) - PORT_OUT_BASE);
  assign fifo_pop   = port_read && sel_fifo && !fifo_empty;
  assign clr_sticky = port_write && sel_status;
  assign wr_out     = port_write && sel_out;
  assign ext_in_ready = !fifo_full;
  assign out_port   = out_q;
  io_port_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (ext_in_valid),
    .pop  (fifo_pop),
    .wdata(ext_in_data),
    .rdata(fifo_rdata),
    .empty(fifo_empty),
    .full (fifo_full)
  );
`ifdef IO_PORT_SYNC_EN
  logic [DATA_WIDTH-1:0] pins_a_s1, pins_a_s2, pins_b_s1, pins_b_s2;
  always_ff @(posedge clock) begin
    if (!reset) begin
      pins_a_s1 <= '0;
      pins_a_s2 <= '0;
      pins_b_s1 <= '0;
      pins_b_s2 <= '0;
    end else begin
      pins_a_s1 <= pins_a;
      pins_a_s2 <= pins_a_s1;
      pins_b_s1 <= pins_b;
      pins_b_s2 <= pins_b_s1;
    end
  end
  assign pins_a_src = pins_a_s2;
  assign pins_b_src = pins_b_s2;
`else
  assign pins_a_src = pins_a;
  assign pins_b_src = pins_b;
`endif
  always_comb begin
    status               = '0;
    status[ST_EMPTY]     = fifo_empty;
    status[ST_FULL]      = fifo_full;
    status[ST_UNDERFLOW] = underflow;
    status[ST_OVERRUN]   = overrun;
  end
  // Empty FIFO reads 0 rather than stale RAM contents; no bypass of a same-cycle push.
  always_comb begin
    rd_val = sel_fifo   ? (fifo_empty ? '0 : fifo_rdata) :
             sel_status ? DATA_WIDTH'(status) :
             sel_pa     ? pins_a_q :
             sel_pb     ? pins_b_q :
             sel_out    ? out_q[out_idx] : '0;
    cpu_rdata = port_read ? rd_val : '0;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      underflow  <= 1'b0;
      overrun    <= 1'b0;
      pins_a_q   <= '0;
      pins_b_q   <= '0;
      out_q      <= '0;
      out_strobe <= '0;
    end else begin
      underflow  <= (port_read && sel_fifo && fifo_empty) || (underflow && !clr_sticky);
      overrun    <= (ext_in_valid && fifo_full && !fifo_pop) || (overrun && !clr_sticky);
      pins_a_q   <= pins_a_src;
      pins_b_q   <= pins_b_src;
      out_strobe <= wr_out ? 4'(1) << out_idx : '0;
      if (wr_out) out_q[out_idx] <= cpu_wdata;
    end
  end
endmodule

// File: tb/tb_io_port_controller.sv
// tb_io_port_controller: directed and random checks of io_port_controller against a queue-based model.
module tb_io_port_controller;
`ifdef IO_PORT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  logic clock = 1'b0, reset = 1'b0, port_read = 1'b0, port_write = 1'b0, ext_in_valid = 1'b0;
  logic [2:0] port_id = '0;
  logic [3:0] cpu_wdata = '0, ext_in_data = '0, pins_a = '0, pins_b = '0;
  logic [3:0] cpu_rdata, out_strobe;
  logic ext_in_ready;
  logic [15:0] out_port;
  int checks = 0, failures = 0;
  logic [3:0] mq[$];
  logic m_ov = 1'b0, m_un = 1'b0;
  logic [3:0] m_out[4];
  logic [3:0] m_strobe = '0;
  logic [3:0] pa_hist[3], pb_hist[3];
  logic [3:0] got_rdata, exp_rdata;

  io_port_controller dut (
    .clock(clock), .reset(reset), .port_id(port_id), .port_read(port_read),
    .port_write(port_write), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
    .pins_a(pins_a), .pins_b(pins_b), .out_port(out_port), .out_strobe(out_strobe)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] model_read(input logic rd, input int id);
    if (!rd) return '0;
    case (id)
      0: return mq.size() > 0 ? mq[0] : 4'h0;
      1: return {m_ov, m_un, mq.size() == 4, mq.size() == 0};
      2: return pa_hist[LAT-1];
      3: return pb_hist[LAT-1];
      default: return m_out[id-4];
    endcase
  endfunction

  function automatic logic [15:0] model_out();
    return {m_out[3], m_out[2], m_out[1], m_out[0]};
  endfunction

  task automatic model_update(input logic rs, rd, wr, input int id, input logic [3:0] wd,
                              input logic v, input logic [3:0] d);
    logic pop, push, ovs, uns;
    if (!rs) begin
      mq.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
      m_strobe = '0;
      for (int i = 0; i < 4; i++) m_out[i] = '0;
      for (int i = 0; i < 3; i++) begin
        pa_hist[i] = '0;
        pb_hist[i] = '0;
      end
      return;
    end
    pop  = rd && id == 0 && mq.size() > 0;
    uns  = rd && id == 0 && mq.size() == 0;
    push = v && (mq.size() < 4 || pop);
    ovs  = v && mq.size() == 4 && !pop;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(d);
    m_ov = ovs || (m_ov && !(wr && id == 1));
    m_un = uns || (m_un && !(wr && id == 1));
    m_strobe = '0;
    if (wr && id >= 4) begin
      m_out[id-4] = wd;
      m_strobe[id-4] = 1'b1;
    end
    pa_hist[2] = pa_hist[1]; pa_hist[1] = pa_hist[0]; pa_hist[0] = pins_a;
    pb_hist[2] = pb_hist[1]; pb_hist[1] = pb_hist[0]; pb_hist[0] = pins_b;
  endtask

  // One bus cycle: drive at posedge+1, capture read data mid-cycle, advance model at the edge.
  task automatic drive(input logic rs, rd, wr, input int id, input logic [3:0] wd,
                       input logic v, input logic [3:0] d);
    reset = rs; port_read = rd; port_write = wr; port_id = 3'(id);
    cpu_wdata = wd; ext_in_valid = v; ext_in_data = d;
    @(negedge clock);
    got_rdata = cpu_rdata;
    exp_rdata = model_read(rd, id);
    @(posedge clock);
    model_update(rs, rd, wr, id, wd, v, d);
    #1;
  endtask

  task automatic idle();               drive(1'b1, 1'b0, 1'b0, 0, 4'h0, 1'b0, 4'h0); endtask
  task automatic rd(input int id);     drive(1'b1, 1'b1, 1'b0, id, 4'h0, 1'b0, 4'h0); endtask
  task automatic wr(input int id, input logic [3:0] v); drive(1'b1, 1'b0, 1'b1, id, v, 1'b0, 4'h0); endtask
  task automatic push(input logic [3:0] d); drive(1'b1, 1'b0, 1'b0, 0, 4'h0, 1'b1, d); endtask

  task automatic test_reset();
    pins_a = '0; pins_b = '0;
    drive(1'b0, 1'b1, 1'b1, 5, 4'hF, 1'b1, 4'h7);
    drive(1'b0, 1'b0, 1'b0, 0, 4'h0, 1'b0, 4'h0);
    checks++; if (out_port !== 16'h0) begin failures++; $display("FAIL reset_out_port got=%h exp=%h", out_port, 16'h0); end
    checks++; if (out_strobe !== 4'h0) begin failures++; $display("FAIL reset_out_strobe got=%b exp=%b", out_strobe, 4'h0); end
    checks++; if (ext_in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ext_in_ready); end
    rd(1);
    checks++; if (got_rdata !== 4'b0001) begin failures++; $display("FAIL reset_status got=%b exp=0001", got_rdata); end
    idle();
    checks++; if (cpu_rdata !== 4'h0) begin failures++; $display("FAIL idle_rdata got=%h exp=0", cpu_rdata); end
  endtask

  task automatic test_stream();
    logic [3:0] vals[4] = '{4'd1, 4'd3, 4'd5, 4'd15};
    for (int i = 0; i < 4; i++) push(vals[i]);
    checks++; if (ext_in_ready !== 1'b0) begin failures++; $display("FAIL stream_ready_full got=%b exp=0", ext_in_ready); end
    rd(1);
    checks++; if (got_rdata !== 4'b0010) begin failures++; $display("FAIL stream_status_full got=%b exp=0010", got_rdata); end
    for (int i = 0; i < 4; i++) begin
      rd(0);
      checks++; if (got_rdata !== vals[i]) begin failures++; $display("FAIL stream_pop%0d got=%0d exp=%0d", i, got_rdata, vals[i]); end
    end
    rd(1);
    checks++; if (got_rdata !== 4'b0001) begin failures++; $display("FAIL stream_status_empty got=%b exp=0001", got_rdata); end
  endtask

  task automatic test_overrun_underflow();
    for (int i = 0; i < 5; i++) push(4'(i + 8));
    rd(1);
    checks++; if (got_rdata !== 4'b1010) begin failures++; $display("FAIL ovr_status got=%b exp=1010", got_rdata); end
    for (int i = 0; i < 5; i++) begin
      rd(0);
      checks++; if (got_rdata !== (i < 4 ? 4'(i + 8) : 4'h0)) begin failures++; $display("FAIL ovr_pop%0d got=%0d exp=%0d", i, got_rdata, (i < 4 ? i + 8 : 0)); end
    end
    rd(1);
    checks++; if (got_rdata !== 4'b1101) begin failures++; $display("FAIL udf_status got=%b exp=1101", got_rdata); end
    wr(1, 4'h0);
    rd(1);
    checks++; if (got_rdata !== 4'b0001) begin failures++; $display("FAIL clear_status got=%b exp=0001", got_rdata); end
  endtask

  task automatic test_outputs();
    wr(5, 4'd14);
    checks++; if (out_port[7:4] !== 4'd14) begin failures++; $display("FAIL out5_value got=%0d exp=14", out_port[7:4]); end
    checks++; if (out_strobe !== 4'b0010) begin failures++; $display("FAIL out5_strobe got=%b exp=0010", out_strobe); end
    idle();
    checks++; if (out_strobe !== 4'b0000) begin failures++; $display("FAIL out5_strobe_drop got=%b exp=0000", out_strobe); end
    rd(5);
    checks++; if (got_rdata !== 4'd14) begin failures++; $display("FAIL out5_read got=%0d exp=14", got_rdata); end
    wr(7, 4'd9);
    checks++; if (out_port !== 16'h90E0) begin failures++; $display("FAIL out7_value got=%h exp=90e0", out_port); end
    checks++; if (out_strobe !== 4'b1000) begin failures++; $display("FAIL out7_strobe got=%b exp=1000", out_strobe); end
    drive(1'b1, 1'b1, 1'b1, 7, 4'd3, 1'b0, 4'h0);
    checks++; if (got_rdata !== 4'd9) begin failures++; $display("FAIL rw_pre_write got=%0d exp=9", got_rdata); end
    checks++; if (out_port[15:12] !== 4'd3) begin failures++; $display("FAIL rw_post_write got=%0d exp=3", out_port[15:12]); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) push(4'(i + 2));
    drive(1'b1, 1'b1, 1'b0, 0, 4'h0, 1'b1, 4'd12);
    checks++; if (got_rdata !== 4'd2) begin failures++; $display("FAIL full_pushpop_read got=%0d exp=2", got_rdata); end
    rd(1);
    checks++; if (got_rdata !== 4'b0010) begin failures++; $display("FAIL full_pushpop_status got=%b exp=0010", got_rdata); end
    drive(1'b1, 1'b0, 1'b1, 1, 4'h0, 1'b1, 4'd1);
    rd(1);
    checks++; if (got_rdata !== 4'b1010) begin failures++; $display("FAIL set_wins_status got=%b exp=1010", got_rdata); end
    wr(1, 4'h0);
    for (int i = 0; i < 4; i++) begin
      rd(0);
      checks++; if (got_rdata !== exp_rdata) begin failures++; $display("FAIL sim_drain%0d got=%0d exp=%0d", i, got_rdata, exp_rdata); end
    end
    drive(1'b1, 1'b1, 1'b0, 0, 4'h0, 1'b1, 4'd6);
    checks++; if (got_rdata !== 4'h0) begin failures++; $display("FAIL empty_pushpop_read got=%0d exp=0", got_rdata); end
    rd(1);
    checks++; if (got_rdata !== 4'b0100) begin failures++; $display("FAIL empty_pushpop_status got=%b exp=0100", got_rdata); end
    rd(0);
    checks++; if (got_rdata !== 4'd6) begin failures++; $display("FAIL empty_pushpop_stored got=%0d exp=6", got_rdata); end
    wr(1, 4'h0);
  endtask

  task automatic test_pins();
    pins_a = 4'd13; pins_b = 4'd6;
    rd(2);
    checks++; if (got_rdata !== 4'd0) begin failures++; $display("FAIL pins_a_early got=%0d exp=0", got_rdata); end
    for (int i = 1; i < LAT; i++) idle();
    rd(2);
    checks++; if (got_rdata !== 4'd13) begin failures++; $display("FAIL pins_a_latency got=%0d exp=13", got_rdata); end
    rd(3);
    checks++; if (got_rdata !== 4'd6) begin failures++; $display("FAIL pins_b_latency got=%0d exp=6", got_rdata); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) push(4'(i + 1));
    wr(6, 4'd11);
    drive(1'b0, 1'b1, 1'b1, 6, 4'd4, 1'b1, 4'd9);
    checks++; if (out_port !== 16'h0) begin failures++; $display("FAIL midrst_out_port got=%h exp=0", out_port); end
    checks++; if (out_strobe !== 4'h0) begin failures++; $display("FAIL midrst_strobe got=%b exp=0", out_strobe); end
    checks++; if (ext_in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", ext_in_ready); end
    rd(1);
    checks++; if (got_rdata !== 4'b0001) begin failures++; $display("FAIL midrst_status got=%b exp=0001", got_rdata); end
    wr(1, 4'h0);
  endtask

  task automatic test_random();
    logic rs, r, w, v;
    int id;
    for (int n = 0; n < 600; n++) begin
      rs = ($urandom_range(0, 63) != 0);
      r = 1'($urandom); w = 1'($urandom); v = 1'($urandom);
      id = int'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin pins_a = 4'($urandom); pins_b = 4'($urandom); end
      drive(rs, r, w, id, 4'($urandom), v, 4'($urandom));
      if (r) begin
        checks++; if (got_rdata !== exp_rdata) begin failures++; $display("FAIL rand_rdata n=%0d id=%0d got=%h exp=%h", n, id, got_rdata, exp_rdata); end
      end
      checks++; if (ext_in_ready !== (mq.size() < 4)) begin failures++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, ext_in_ready, mq.size() < 4); end
      checks++; if (out_port !== model_out()) begin failures++; $display("FAIL rand_out_port n=%0d got=%h exp=%h", n, out_port, model_out()); end
      checks++; if (out_strobe !== m_strobe) begin failures++; $display("FAIL rand_strobe n=%0d got=%b exp=%b", n, out_strobe, m_strobe); end
    end
  endtask

  initial begin
    @(posedge clock);
    #1;
    test_reset();
    test_stream();
    test_overrun_underflow();
    test_outputs();
    test_simultaneous();
    test_pins();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
